// File: rtl/fetch_redirect_stage.sv
// Fetch-side sink for pipeline redirect/stall controls: owns the PC, the IF/ID
// register, the ID/EX clear strobe and saturating redirect/stall counters.
module fetch_redirect_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IFflush,
  input  logic             IDflush,
  input  logic [31:0]      redirect_pc,
  input  logic             stall,
  input  logic [31:0]      imem_inst,
  output logic [31:0]      pc_out,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_inst,
  output logic             if_id_valid,
  output logic             id_ex_clr,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned XLEN    = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_if_id_pc;
  logic [XLEN-1:0]  r_if_id_inst;
  logic             r_if_id_valid;
  logic [CNT_W-1:0] r_redirect_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall_applied;

  // A stall only takes effect when no older redirect is squashing the pipe.
  assign w_stall_applied = stall & ~IFflush;

  // PC and IF/ID update, priority redirect > stall > advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_if_id_pc    <= '0;
      r_if_id_inst  <= NOP_INST;
      r_if_id_valid <= 1'b0;
    end else if (IFflush) begin
      r_pc          <= redirect_pc;
      r_if_id_pc    <= redirect_pc;
      r_if_id_inst  <= NOP_INST;
      r_if_id_valid <= 1'b0;
    end else if (!stall) begin
      r_pc          <= r_pc + PC_STEP;
      r_if_id_pc    <= r_pc;
      r_if_id_inst  <= imem_inst;
      r_if_id_valid <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (IFflush && (r_redirect_cnt != CNT_MAX)) begin
        r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
      end
      if (w_stall_applied && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign id_ex_clr    = IDflush | w_stall_applied;
  assign pc_out       = r_pc;
  assign if_id_pc     = r_if_id_pc;
  assign if_id_inst   = r_if_id_inst;
  assign if_id_valid  = r_if_id_valid;
  assign redirect_cnt = r_redirect_cnt;
  assign stall_cnt    = r_stall_cnt;

endmodule
